fas_spectrum_analyzer: RTL
==========================

// Module: fas_spectrum_analyzer
//
// PURPOSE
// Parametrised successor of the FAS analysis stage. Accepts one complex FFT
// bin per cycle over a valid/ready handshake, forms |X|^2 with a one-stage
// pipeline and tracks the dominant bin over an NPOINT-bin frame. At end of
// frame it reports the peak index and magnitude with a one-cycle done pulse.
// It sits between the FFT and the frequency-report logic.
//
// PARAMETERS
// NPOINT  16                    bins per frame; power of two, 4..1024
// DW      16                    width of each signed real/imag input
// IDX_W   $clog2(NPOINT)        bin index width (derived; do not override)
// MAG_W   2*DW                  unsigned magnitude-squared width (derived)
//
// PORTS
// clk        in   1      clock, rising edge
// rst        in   1      synchronous reset, active-low
// bin_valid  in   1      bin_re/bin_im valid this cycle
// bin_ready  out  1      block can accept a bin this cycle
// bin_re     in   DW     signed real part of the current bin
// bin_im     in   DW     signed imaginary part of the current bin
// done       out  1      one-cycle pulse: frame result valid
// freq       out  IDX_W  index of the peak bin, held until next done
// peak_mag   out  MAG_W  re^2+im^2 of the peak bin, held until next done
// frame_cnt  out  8      completed frames, wraps 255->0
// thresh     in   MAG_W  [FAS_THRESH_EN only] minimum valid peak magnitude
// peak_found out  1      [FAS_THRESH_EN only] peak_mag >= thresh, held with freq
//
// BEHAVIOUR
// - Reset (rst==0 at clk edge): state=ACC, bin counter=0, max regs=0,
//   bin_ready=1, done=0, freq=0, peak_mag=0, frame_cnt=0, peak_found=0.
//   Reset mid-frame discards the partial frame; no done is produced.
// - Accept = bin_valid & bin_ready. bin_valid while bin_ready==0 is ignored;
//   it is neither buffered nor counted.
// - Bin index = number of bins accepted earlier in the frame (0..NPOINT-1).
// - Stage 1 registers mag = re*re + im*im (unsigned, MAG_W bits; cannot
//   overflow: worst case 2*2^(2DW-2)) together with its index.
// - Stage 2: if mag > running max (strict), max <= mag, max_idx <= index.
//   Ties keep the lowest index. The first bin of a frame always loads max.
// - FSM: ACC -> DRAIN on accept of bin NPOINT-1; DRAIN -> REPORT after one
//   cycle; REPORT -> ACC after one cycle. bin_ready=1 only in ACC.
// - Latency: last bin accepted at edge t; done=1 during cycle t+2 with freq,
//   peak_mag updated at that same edge; bin_ready=0 during cycles t+1, t+2;
//   bin_ready=1 again at t+3. Max regs clear on REPORT->ACC.
// - frame_cnt increments on the edge where done rises.
// - Gaps in bin_valid within a frame are allowed; the frame has no timeout.
//
// CONFIGURATION
// FAS_THRESH_EN defined: thresh/peak_found ports exist; peak_found is
//   registered with done as (final max >= thresh); freq/peak_mag still report
//   the peak either way. Undefined: ports absent, no comparator; all
//   other behaviour identical.
//
// TESTING (NPOINT=16, DW=16)
// 1. Reset, 16 bins all 0 except bin 5 = (300,400) -> done 2 cycles after last
//    accept, freq=5, peak_mag=250000, frame_cnt=1.
// 2. Bins 3 and 9 both (-100,0), rest 0 -> freq=3, peak_mag=10000 (tie
//    keeps lowest index).
// 3. bin 15 = (-32768,-32768) -> peak_mag=0x8000_0000, freq=15 (no overflow).
// 4. Back-to-back frames with bin_valid held 1 -> bin_ready low 2 cycles per
//    frame, held bins not counted; 256 frames -> frame_cnt wraps to 0.
// 5. rst low after 10 bins, then full frame with peak at bin 2 -> exactly one
//    done, freq=2, partial frame has no effect.
// 6. FAS_THRESH_EN, thresh=1000: peak (10,10) -> peak_found=0, freq still
//    reported; peak (40,0) -> peak_found=1, peak_mag=1600.

Source files
------------

// File: rtl/fas_spectrum_analyzer.sv
// -----------------------------------------------------------------------------
// fas_spectrum_analyzer
//
// Peak-bin tracker for the FAS analysis stage. Takes one complex FFT bin per
// cycle over a valid/ready handshake, forms |X|^2 in one registered stage and
// keeps a running maximum over an NPOINT-bin frame. At end of frame the peak
// index and magnitude are reported alongside a one-cycle done pulse.
//
// Optional feature macro: FAS_THRESH_EN
//   When defined, adds a threshold input and a peak_found flag that is
//   registered together with done as (final peak magnitude >= thresh).
//
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous reset, active-low
//   bin_valid   in   1      bin_re/bin_im valid this cycle
//   bin_ready   out  1      block can accept a bin this cycle
//   bin_re      in   DW     signed real part of the current bin
//   bin_im      in   DW     signed imaginary part of the current bin
//   done        out  1      one-cycle pulse: frame result valid
//   freq        out  IDX_W  index of the peak bin, held until next done
//   peak_mag    out  MAG_W  re^2+im^2 of the peak bin, held until next done
//   frame_cnt   out  8      completed frames, wraps 255->0
//   thresh      in   MAG_W  [FAS_THRESH_EN] minimum valid peak magnitude
//   peak_found  out  1      [FAS_THRESH_EN] peak_mag >= thresh, held with freq
// -----------------------------------------------------------------------------
module fas_spectrum_analyzer #(
    parameter  int NPOINT = 16,
    parameter  int DW     = 16,
    localparam int IDX_W  = $clog2(NPOINT),
    localparam int MAG_W  = 2 * DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bin_valid,
    output logic             bin_ready,
    input  logic [DW-1:0]    bin_re,
    input  logic [DW-1:0]    bin_im,
    output logic             done,
    output logic [IDX_W-1:0] freq,
    output logic [MAG_W-1:0] peak_mag,
    output logic [7:0]       frame_cnt
`ifdef FAS_THRESH_EN
    ,
    input  logic [MAG_W-1:0] thresh,
    output logic             peak_found
`endif
);

    localparam logic [1:0] ST_ACC    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] bin_cnt;
    logic             accept;

    // Stage 1: registered magnitude and its bin index.
    logic             s1_valid;
    logic [MAG_W-1:0] s1_mag;
    logic [IDX_W-1:0] s1_idx;

    // Stage 2: running maximum for the current frame.
    logic [MAG_W-1:0] max_mag;
    logic [IDX_W-1:0] max_idx;

    logic signed [MAG_W-1:0] re_ext, im_ext, re_sq, im_sq;
    logic [MAG_W-1:0]        mag_in;
    logic                    take;
    logic [MAG_W-1:0]        nxt_mag;
    logic [IDX_W-1:0]        nxt_idx;

    assign bin_ready = (state == ST_ACC);
    assign accept    = bin_valid & bin_ready;

    // Squares are formed at full MAG_W width from sign-extended operands. The
    // sum can reach exactly 2^(MAG_W-1) (both parts at the most negative
    // value), which wraps the signed add but is the correct unsigned pattern.
    assign re_ext = MAG_W'($signed(bin_re));
    assign im_ext = MAG_W'($signed(bin_im));
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;
    assign mag_in = re_sq + im_sq;

    // NOTE: combinational logic uses blocking '=' and gives every output a
    // default first, so no path leaves a value unassigned (no latch).
    always_comb begin
        take    = 1'b0;
        nxt_mag = max_mag;
        nxt_idx = max_idx;
        // Strict '>' keeps the lowest index on ties; bin 0 always loads so a
        // frame never inherits anything from the cleared registers.
        if (s1_valid && (s1_idx == '0 || s1_mag > max_mag)) begin
            take = 1'b1;
        end
        if (take) begin
            nxt_mag = s1_mag;
            nxt_idx = s1_idx;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' only, and every register
    // here is reset (there is no memory array, so nothing is left unreset).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_ACC;
            bin_cnt   <= '0;
            s1_valid  <= 1'b0;
            s1_mag    <= '0;
            s1_idx    <= '0;
            max_mag   <= '0;
            max_idx   <= '0;
            done      <= 1'b0;
            freq      <= '0;
            peak_mag  <= '0;
            frame_cnt <= '0;
`ifdef FAS_THRESH_EN
            peak_found <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            s1_valid <= accept;
            max_mag  <= nxt_mag;
            max_idx  <= nxt_idx;

            if (accept) begin
                s1_mag  <= mag_in;
                s1_idx  <= bin_cnt;
                // NPOINT is a power of two, so the counter wraps to 0 itself.
                bin_cnt <= bin_cnt + 1'b1;
            end

            case (state)
                ST_ACC: begin
                    if (accept && bin_cnt == IDX_W'(NPOINT - 1)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The last bin sits in stage 1 now; report the merged
                    // result directly so done lands one cycle later.
                    state     <= ST_REPORT;
                    done      <= 1'b1;
                    freq      <= nxt_idx;
                    peak_mag  <= nxt_mag;
                    frame_cnt <= frame_cnt + 8'd1;
`ifdef FAS_THRESH_EN
                    peak_found <= (nxt_mag >= thresh);
`endif
                end
                ST_REPORT: begin
                    state   <= ST_ACC;
                    max_mag <= '0;
                    max_idx <= '0;
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end

endmodule
